// File: rtl/stage_2_nbool_pipe.sv
`default_nettype none
// =====================================================================
// stage_2_nbool_pipe
//   Range stage for the entropy encoder: one Q15 CDF encode or up to
//   N_BOOL chained 50% bool encodes per beat. Each result is
//   renormalised once. Output sits behind a valid/ready register.
// Revision: 1.0
// =====================================================================
module stage_2_nbool_pipe #(
  parameter int RANGE_WIDTH  = 16,
  parameter int D_SIZE       = 5,
  parameter int SYMBOL_WIDTH = 4,
  parameter int N_BOOL       = 4,
  parameter logic [RANGE_WIDTH-1:0] RANGE_RESET = 16'h8000,
  localparam int CNT_W = $clog2(N_BOOL + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             restart,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [RANGE_WIDTH-1:0]           UU,
  input  logic [RANGE_WIDTH-1:0]           VV,
  input  logic [RANGE_WIDTH-1:0]           lut_u,
  input  logic [RANGE_WIDTH-1:0]           lut_v,
  input  logic                             COMP_mux_1,
  input  logic [CNT_W-1:0]                 bool_count,
  input  logic [N_BOOL*SYMBOL_WIDTH-1:0]   symbols,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RANGE_WIDTH:0]             u_out,
  output logic [RANGE_WIDTH-1:0]           out_range,
  output logic [N_BOOL*RANGE_WIDTH-1:0]    initial_range,
  output logic [N_BOOL*RANGE_WIDTH-1:0]    pre_low,
  output logic [N_BOOL*D_SIZE-1:0]         out_d,
  output logic [N_BOOL-1:0]                bool_mask,
  output logic [N_BOOL-1:0]                sym_bits,
  output logic                             comp_out
);

  localparam int PROD_W = 2 * RANGE_WIDTH - 8;

  logic                                   r_ready_en;
  logic                                   r_out_valid;
  logic [RANGE_WIDTH-1:0]                 r_range;
  logic [RANGE_WIDTH:0]                   r_u;
  logic [RANGE_WIDTH-1:0]                 r_range_out;
  logic [N_BOOL-1:0][RANGE_WIDTH-1:0]     r_init;
  logic [N_BOOL-1:0][RANGE_WIDTH-1:0]     r_pre;
  logic [N_BOOL-1:0][D_SIZE-1:0]          r_d;
  logic [N_BOOL-1:0]                      r_mask;
  logic [N_BOOL-1:0]                      r_sym;
  logic                                   r_comp;

  logic                                   w_accept;
  logic [RANGE_WIDTH-1:0]                 w_r0;
  logic [CNT_W-1:0]                       w_k;
  logic [PROD_W-1:0]                      w_prod_u;
  logic [PROD_W-1:0]                      w_prod_v;
  logic [RANGE_WIDTH:0]                   w_u;
  logic [RANGE_WIDTH:0]                   w_v;
  logic [RANGE_WIDTH-1:0]                 w_cdf_raw;
  logic [D_SIZE-1:0]                      w_cdf_d;
  logic [N_BOOL-1:0][RANGE_WIDTH-1:0]     w_init;
  logic [N_BOOL-1:0][RANGE_WIDTH-1:0]     w_pre;
  logic [N_BOOL-1:0][D_SIZE-1:0]          w_d;
  logic [N_BOOL-1:0]                      w_mask;
  logic [N_BOOL-1:0]                      w_sym;
  logic [RANGE_WIDTH-1:0]                 w_range_nxt;
  logic [RANGE_WIDTH:0]                   w_u_nxt;
  logic                                   w_unused;

  // Leading-zero count; an all-zero value normalises by the maximum shift.
  function automatic logic [D_SIZE-1:0] f_lzc(input logic [RANGE_WIDTH-1:0] x);
    logic [D_SIZE-1:0] n;
    logic              found;
    n     = D_SIZE'(RANGE_WIDTH - 1);
    found = 1'b0;
    for (int i = RANGE_WIDTH - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = D_SIZE'(RANGE_WIDTH - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  assign in_ready = r_ready_en & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_r0     = restart ? RANGE_RESET : r_range;
  assign w_k      = (bool_count > CNT_W'(N_BOOL)) ? CNT_W'(N_BOOL) : bool_count;

  assign w_prod_u  = PROD_W'(w_r0[RANGE_WIDTH-1:8]) * PROD_W'(UU);
  assign w_prod_v  = PROD_W'(w_r0[RANGE_WIDTH-1:8]) * PROD_W'(VV);
  assign w_u       = w_prod_u[RANGE_WIDTH+1:1] + {1'b0, lut_u};
  assign w_v       = w_prod_v[RANGE_WIDTH+1:1] + {1'b0, lut_v};
  assign w_cdf_raw = COMP_mux_1 ? (w_u[RANGE_WIDTH-1:0] - w_v[RANGE_WIDTH-1:0])
                                : (w_r0 - w_v[RANGE_WIDTH-1:0]);
  assign w_cdf_d   = f_lzc(w_cdf_raw);

  // Only bit 0 of each symbol lane and the middle product bits carry meaning.
  assign w_unused = ^{symbols, w_prod_u, w_prod_v, w_v};

  for (genvar g = 0; g < N_BOOL; g++) begin : g_sym
    assign w_sym[g] = symbols[g*SYMBOL_WIDTH];
  end

  always_comb begin
    logic [RANGE_WIDTH-1:0] w_r;
    logic [RANGE_WIDTH-1:0] w_bv;
    logic [RANGE_WIDTH-1:0] w_bpre;
    logic [RANGE_WIDTH-1:0] w_braw;
    logic [D_SIZE-1:0]      w_bd;
    w_init      = '0;
    w_pre       = '0;
    w_d         = '0;
    w_mask      = '0;
    w_u_nxt     = '0;
    w_range_nxt = w_r0;
    w_r         = w_r0;
    w_bv        = '0;
    w_bpre      = '0;
    w_braw      = '0;
    w_bd        = '0;
    if (w_k == '0) begin
      w_init[0]   = w_r0;
      w_d[0]      = w_cdf_d;
      w_u_nxt     = w_u;
      w_range_nxt = w_cdf_raw << w_cdf_d;
    end else begin
      // Each active bin renormalises by at most two, feeding the next bin.
      for (int i = 0; i < N_BOOL; i++) begin
        if (CNT_W'(i) < w_k) begin
          w_bv      = ((w_r >> 8) << 7) + RANGE_WIDTH'(4);
          w_bpre    = w_r - w_bv;
          w_braw    = w_sym[i] ? w_bv : w_bpre;
          w_bd      = w_braw[RANGE_WIDTH-1] ? D_SIZE'(0) :
                      w_braw[RANGE_WIDTH-2] ? D_SIZE'(1) : D_SIZE'(2);
          w_init[i] = w_r;
          w_pre[i]  = w_bpre;
          w_d[i]    = w_bd;
          w_mask[i] = 1'b1;
          w_r       = w_braw << w_bd;
        end
      end
      w_range_nxt = w_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_range     <= RANGE_RESET;
      r_u         <= '0;
      r_range_out <= '0;
      r_init      <= '0;
      r_pre       <= '0;
      r_d         <= '0;
      r_mask      <= '0;
      r_sym       <= '0;
      r_comp      <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_range     <= w_range_nxt;
        r_u         <= w_u_nxt;
        r_range_out <= w_range_nxt;
        r_init      <= w_init;
        r_pre       <= w_pre;
        r_d         <= w_d;
        r_mask      <= w_mask;
        r_sym       <= w_sym;
        r_comp      <= COMP_mux_1;
      end else begin
        if (out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (restart) begin
          r_range <= RANGE_RESET;
        end
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign u_out         = r_u;
  assign out_range     = r_range_out;
  assign initial_range = r_init;
  assign pre_low       = r_pre;
  assign out_d         = r_d;
  assign bool_mask     = r_mask;
  assign sym_bits      = r_sym;
  assign comp_out      = r_comp;

endmodule
`default_nettype wire
